avg_packer: RTL and testbench

AVG_PACKER -- requirements
Module: avg_packer

---
 rtl/avg_packer.sv | 148 ++++++++++++++
 tb/tb_avg_packer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/avg_packer.sv
// avg_packer: packs pairs of N-bit averaged samples into 32-bit words
// (first sample in the low half) and queues them in a first-word-fall-through
// FIFO. A flush pulse emits a lone pending sample with a zero upper half.
// Words completed while the FIFO is full and not being drained are dropped
// and recorded in a sticky overflow flag.
module avg_packer #(
  parameter int N     = 14,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   r_half;
  logic          r_pending;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;

  logic [15:0]   w_sample;
  logic          w_push;
  logic [31:0]   w_word;
  logic          w_pending_nxt;
  logic          w_load_half;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;

  // Pointer advance with explicit wrap at DEPTH.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = p + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Zero-extend the incoming sample to a 16-bit half word.
  always_comb begin
    w_sample        = 16'h0000;
    w_sample[N-1:0] = in_data[N-1:0];
  end

  // Pairing and flush decision: a new sample completes a pending word before
  // any flush is considered; flush only acts on a sample left pending.
  always_comb begin
    w_push        = 1'b0;
    w_word        = 32'h0000_0000;
    w_pending_nxt = r_pending;
    w_load_half   = 1'b0;
    if (in_valid) begin
      if (r_pending) begin
        w_push        = 1'b1;
        w_word        = {w_sample, r_half};
        w_pending_nxt = 1'b0;
      end else begin
        w_load_half   = 1'b1;
        w_pending_nxt = 1'b1;
      end
    end else if (flush && r_pending) begin
      w_push        = 1'b1;
      w_word        = {16'h0000, r_half};
      w_pending_nxt = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // FIFO handshake: a push into a full FIFO survives only alongside a pop.
  always_comb begin
    w_full    = (r_count == LW'(DEPTH));
    w_pop     = out_valid && out_ready;
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  // Half register and pending flag for the first sample of a pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_half    <= 16'h0000;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_load_half) begin
        r_half <= w_sample;
      end
    end
  end

  // FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push_ok && rst) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_count    <= {LW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(LW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head word presented straight from the storage registers.
  always_comb begin
    out_valid = (r_count != {LW{1'b0}});
    if (out_valid) begin
      out_data = r_mem[r_rptr];
    end else begin
      out_data = 32'h0000_0000;
    end
    level    = r_count;
    overflow = r_overflow;
  end

endmodule

// File: tb/tb_avg_packer.sv
// Scoreboard bench for avg_packer: a queue-based reference model predicts
// FIFO contents, occupancy and overflow; a negedge monitor compares.
module tb_avg_packer;

  localparam int N     = 14;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [LW-1:0] level;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [15:0] pend_q[$];   // samples waiting for a partner
  logic [31:0] exp_q[$];    // expected words in FIFO order
  int          m_level = 0;
  bit          m_ovf = 1'b0;

  avg_packer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: applies the packing and FIFO rules at each rising edge.
  always @(posedge clk) begin
    logic [31:0] w;
    bit have, pop;
    if (!rst) begin
      pend_q.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
    end else begin
      pop  = (m_level > 0) && out_ready;
      have = 1'b0;
      w    = 32'h0;
      if (in_valid) begin
        if (pend_q.size() > 0) begin
          w = {16'(in_data), pend_q.pop_front()};
          have = 1'b1;
        end else begin
          pend_q.push_back(16'(in_data));
        end
      end else if (flush && pend_q.size() > 0) begin
        w = {16'h0000, pend_q.pop_front()};
        have = 1'b1;
      end
      if (have) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(w);
          if (!pop) m_level++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (pop) begin
        m_level--;
      end
    end
  end

  // Monitor: compares visible state and retires words on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 32'(level), 32'(m_level));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_valid", 32'(out_valid), 32'(m_level != 0));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] d, input bit f, input bit r);
    in_valid  = v;
    in_data   = d[N-1:0];
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", out_data, 32'h0);

    // Pair packing
    cyc(1'b1, 16'h007F, 1'b0, 1'b0);
    cyc(1'b1, 16'h0007, 1'b0, 1'b0);
    chk("pair_data", out_data, 32'h0007_007F);
    chk("pair_level", 32'(level), 32'd1);

    // Flush of a lone sample, then a second flush with nothing pending
    do_reset();
    cyc(1'b1, 16'h0070, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush_data", out_data, 32'h0000_0070);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush2_level", 32'(level), 32'd1);

    // Fill past full, then drain
    do_reset();
    for (int i = 0; i < 2*DEPTH+2; i++) cyc(1'b1, 16'(i+1), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head", out_data, 32'h0002_0001);
    for (int i = 0; i < DEPTH+2; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("drain_level", 32'(level), 32'd0);

    // Simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 2*DEPTH; i++) cyc(1'b1, 16'(i+16'h0100), 1'b0, 1'b0);
    cyc(1'b1, 16'h0AAA, 1'b0, 1'b0);
    cyc(1'b1, 16'h0555, 1'b0, 1'b1);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'(i+16'h0010), 1'b0, 1'b0);
    cyc(1'b1, 16'h003F, 1'b0, 1'b0);
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 16'h0001, 1'b0, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    chk("rst_pair", out_data, 32'h0002_0001);

    // Backpressure toggling
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i*16'h0111), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0, 1'b0, 1'(i % 2));

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) == 0));
      end
    end
    for (int i = 0; i < DEPTH+2; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("final_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
